// File: rtl/float_arith_pkg.sv
// Shared constants and helpers for the small-float arithmetic blocks.
// Word format is {sign, exponent, stored mantissa} with an implicit leading one.
package float_arith_pkg;

    typedef enum logic [1:0] {
        FLAG_NONE = 2'd0,
        FLAG_OVF  = 2'd1,
        FLAG_UNF  = 2'd2
    } flag_e;

    function automatic int word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int prod_w(input int man_w);
        return 2 * man_w + 2;
    endfunction

endpackage

// File: rtl/mant_mult_pipe.sv
// Two-stage registered unsigned multiplier: operands are captured first,
// the product is registered one enabled cycle later.
module mant_mult_pipe #(
    parameter int N = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    logic [N-1:0] a_q;
    logic [N-1:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p   <= '0;
        end else if (en) begin
            a_q <= a;
            b_q <= b;
            p   <= (2*N)'(a_q) * (2*N)'(b_q);
        end
    end

endmodule

// File: rtl/float_mult_param.sv
// Parameterised 3-stage floating-point multiplier with valid/ready handshake.
// No subnormals, infinities or NaN; out-of-range results saturate or flush to zero.
module float_mult_param
    import float_arith_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [EXP_W+MAN_W:0]   data_1_i,
    input  logic [EXP_W+MAN_W:0]   data_2_i,
    input  logic                   rnd_mode_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [EXP_W+MAN_W:0]   data_mult_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int W    = word_w(EXP_W, MAN_W);
    localparam int BIAS = bias_of(EXP_W);
    localparam int PW   = prod_w(MAN_W);
    localparam int EW   = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_S = '0;

    logic en;
    assign en      = !valid_o || ready_i;
    assign ready_o = en;

    // S1: unpack, exponent sum, sign, zero detect; multiplier captures operands
    logic             s1_valid, s1_sign, s1_zero, s1_rnd;
    logic [EXP_W:0]   s1_esum;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_esum  <= '0;
        end else if (en) begin
            s1_valid <= valid_i;
            s1_sign  <= data_1_i[W-1] ^ data_2_i[W-1];
            s1_zero  <= (data_1_i[W-2:0] == '0) || (data_2_i[W-2:0] == '0);
            s1_rnd   <= rnd_mode_i;
            s1_esum  <= {1'b0, data_1_i[W-2:MAN_W]} + {1'b0, data_2_i[W-2:MAN_W]};
        end
    end

    logic [PW-1:0] prod;

    mant_mult_pipe #(.N(MAN_W + 1)) u_mant_mult (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (en),
        .a     ({1'b1, data_1_i[MAN_W-1:0]}),
        .b     ({1'b1, data_2_i[MAN_W-1:0]}),
        .p     (prod)
    );

    // S2: product completes inside the multiplier; remove the bias
    logic                  s2_valid, s2_sign, s2_zero, s2_rnd;
    logic signed [EW-1:0]  s2_exp;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_rnd   <= 1'b0;
            s2_exp   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_rnd   <= s1_rnd;
            s2_exp   <= $signed({1'b0, s1_esum}) - BIAS_S;
        end
    end

    // S3: normalise, round, then classify
    logic                  norm, guard;
    logic [MAN_W-1:0]      man_t;
    logic [MAN_W:0]        man_r;
    logic [1:0]            exp_inc;
    logic signed [EW-1:0]  er;
    logic [W-1:0]          res;
    flag_e                 flag;
    logic                  unused_low_bits;

    assign unused_low_bits = ^prod[MAN_W-2:0];

    always_comb begin
        norm    = prod[PW-1];
        man_t   = norm ? prod[PW-2 -: MAN_W] : prod[PW-3 -: MAN_W];
        guard   = norm ? prod[MAN_W] : prod[MAN_W-1];
        man_r   = {1'b0, man_t} + {{MAN_W{1'b0}}, s2_rnd & guard};
        exp_inc = {1'b0, norm} + {1'b0, man_r[MAN_W]};
        er      = s2_exp + $signed({{(EW-2){1'b0}}, exp_inc});
        res     = '0;
        flag    = FLAG_NONE;
        if (s2_zero) begin
            res  = '0;
            flag = FLAG_NONE;
        end else if (er <= ZERO_S) begin
            res  = '0;
            flag = FLAG_UNF;
        end else if (er >= EMAX_S) begin
            res  = {s2_sign, {(W-1){1'b1}}};
            flag = FLAG_OVF;
        end else begin
            // a rounding carry leaves man_r's low bits at zero already
            res  = {s2_sign, er[EXP_W-1:0], man_r[MAN_W-1:0]};
            flag = FLAG_NONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o     <= 1'b0;
            data_mult_o <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (en) begin
            valid_o     <= s2_valid;
            data_mult_o <= res;
            overflow_o  <= (flag == FLAG_OVF);
            underflow_o <= (flag == FLAG_UNF);
        end
    end

endmodule

// File: doc/float_mult_param.md
FLOAT_MULT_PARAM -- requirements
Module: float_mult_param

Interface
REQ-001 The module SHALL have parameter EXP_W, default 5, meaning the exponent field width.
REQ-002 The module SHALL have parameter MAN_W, default 6, meaning the stored mantissa field width, with the hidden 1 implicit.
REQ-003 The module SHALL derive local constants W = 1+EXP_W+MAN_W (word width) and BIAS = 2^(EXP_W-1)-1; the word format is {sign, exp, man}.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-006 valid_i  input  1  operand pair valid.
REQ-007 ready_o  output  1  block can accept the operand pair this cycle.
REQ-008 data_1_i  input  W  operand A.
REQ-009 data_2_i  input  W  operand B.
REQ-010 rnd_mode_i  input  1  rounding mode: 0 = truncate, 1 = round-half-up; sampled with the operands.
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  downstream accepts the result.
REQ-013 data_mult_o  output  W  product.
REQ-014 overflow_o  output  1  result saturated; qualified by valid_o.
REQ-015 underflow_o  output  1  result flushed to zero; qualified by valid_o.

Function
REQ-016 A transfer SHALL occur when valid_i && ready_o; the output handshake completes when valid_o && ready_i.
REQ-017 The block SHALL be a 3-stage pipeline: S1 unpacks operands, sums exponents, XORs signs and starts the mantissa multiply; S2 completes the multiply and subtracts BIAS; S3 normalises, rounds, saturates and registers the outputs.
REQ-018 The block SHALL accept one operation per cycle with no bubbles.
REQ-019 Latency SHALL be 3 cycles from the accepting edge to valid_o high, provided no stall occurs.
REQ-020 Stall: the global pipeline enable SHALL be en = !valid_o || ready_i, and ready_o SHALL equal en.
REQ-021 While en is low, all stage registers, including the data and flags on the outputs, SHALL hold their values.
REQ-022 Each stage SHALL carry a valid bit; a bubble (valid low) SHALL propagate without asserting valid_o.
REQ-023 The unsigned product of {1,manA} and {1,manB} SHALL be 2*MAN_W+2 bits wide.
REQ-024 If product bit [2*MAN_W+1] is set, the product SHALL be shifted right by one and the exponent incremented by one.
REQ-025 The biased exponent SHALL be computed as er = eA + eB - BIAS + norm, held signed with EXP_W+2 bits.
REQ-026 In mode 1, rounding SHALL add the guard bit (the first bit below the mantissa LSB) to the mantissa.
REQ-027 A mantissa carry-out from rounding SHALL zero the mantissa and increment er.
REQ-028 Zero operand: if either operand has all non-sign bits equal to 0, the result SHALL be all-zero with sign 0 and both flags low.
REQ-029 Underflow: if er <= 0 after normalisation and rounding, the result SHALL be all-zero with sign 0 and underflow_o = 1.
REQ-030 Overflow: if er >= 2^EXP_W-1, the result SHALL be {sign, all ones, all ones} and overflow_o = 1.
REQ-031 Otherwise the result SHALL be {sA^sB, er[EXP_W-1:0], mantissa}.
REQ-032 Subnormals, infinities and NaN SHALL NOT be supported; an exponent field of 0 with a non-zero mantissa SHALL be treated as a normal number.

Reset
REQ-033 While rst_n_i is low, every stage valid bit, valid_o, data_mult_o, overflow_o and underflow_o SHALL be 0, applied asynchronously.
REQ-034 Assertion of reset mid-operation SHALL discard all in-flight operations.
REQ-035 The first accepted operation after reset release SHALL emerge exactly 3 cycles later.
REQ-036 While rst_n_i is low, ready_o SHALL be 1.

Structure
REQ-037 A shared package float_arith_pkg SHALL hold the width and bias constant functions and the flag encoding.
REQ-038 Exactly one sub-module, mant_mult_pipe, SHALL be used: a 2-stage registered unsigned (MAN_W+1)x(MAN_W+1) multiplier with enable input en.
REQ-039 No vendor IP SHALL be instantiated.

Verification (defaults EXP_W=5, MAN_W=6)
REQ-040 0x3C0 x 0x3C0 -> 0x3C0, and 0x3E0 x 0x3E0 -> 0x408; 0xC00 x 0x3E0 -> 0xC20; each arrives exactly 3 cycles after acceptance, flags 0.
REQ-041 0x3E1 x 0x3E1 with rnd_mode_i = 0 -> 0x409; with rnd_mode_i = 1 -> 0x40A.
REQ-042 0x780 x 0x780 -> 0x7FF, overflow_o = 1; 0x040 x 0x040 -> 0x000, underflow_o = 1; 0x800 x 0x3C0 -> 0x000, flags 0.
REQ-043 Stream 10 back-to-back operations, holding ready_i low for 4 cycles mid-stream -> ready_o low during the stall, no result lost or duplicated, results in order.
REQ-044 Pulse rst_n_i low while 3 operations are in flight -> outputs 0 immediately; no stale valid_o after reset release.
REQ-045 Rerun the random and directed checks with EXP_W=8 and MAN_W=10 against a reference model.
